// File: rtl/umtrx_multi_rx_framer.sv
// umtrx_multi_rx_framer: per-channel sample buffers feeding a round-robin packet framer.
// Packets are HDR, TSH, TSL, then spp_eff samples, on one 36-bit {EOF,SOF,payload} stream.
module umtrx_multi_rx_framer #(
  parameter int unsigned NCHAN      = 2,
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned BASE       = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_stb,
  input  logic [7:0]          set_addr,
  input  logic [31:0]         set_data,
  input  logic [NCHAN*32-1:0] sample,
  input  logic [NCHAN-1:0]    strobe,
  input  logic [63:0]         vita_time,
  output logic [NCHAN-1:0]    run,
  output logic [NCHAN-1:0]    overrun,
  output logic [35:0]         data_o,
  output logic                src_rdy_o,
  input  logic                dst_rdy_i
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned OW    = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {StIdle, StHdr, StTsh, StTsl, StData} state_e;

  // Settings and per-channel state
  logic [NCHAN-1:0] enable_q;
  logic [15:0]      spp_q;
  logic             clear_q;
  logic [NCHAN-1:0] overrun_q;
  logic [OW-1:0]    occ_q    [NCHAN];
  logic [AW-1:0]    wr_ptr_q [NCHAN];
  logic [AW-1:0]    rd_ptr_q [NCHAN];
  logic [15:0]      cnt_q    [NCHAN];
  logic [7:0]       seq_q    [NCHAN];
  logic [96:0]      mem_q    [NCHAN][DEPTH];

  // Output framer state
  state_e      state_q, state_d;
  logic [CW-1:0] gnt_q, gnt_d, last_q, last_d;
  logic [15:0] rem_q, rem_d;
  logic [35:0] data_q, data_d;
  logic        src_rdy_q, src_rdy_d;

  logic [15:0]      spp_eff;
  logic [NCHAN-1:0] full, wr_en, ready, pop_vec, seq_inc;
  logic             xfer, pop, eof_xfer, do_clear, grant_vld;
  logic [CW-1:0]    grant_ch;
  logic [96:0]      head;
  logic             unused_bits;

  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int unsigned off);
    return CW'((32'(base) + off) % NCHAN);
  endfunction

  assign run       = enable_q & ~overrun_q & {NCHAN{~clear_q}};
  assign overrun   = overrun_q;
  assign data_o    = data_q;
  assign src_rdy_o = src_rdy_q;
  assign xfer      = src_rdy_q & dst_rdy_i;
  assign pop       = xfer & ((state_q == StTsl) | ((state_q == StData) & ~data_q[33]));
  assign eof_xfer  = xfer & (state_q == StData) & data_q[33];
  assign do_clear  = (state_q == StIdle) & clear_q;
  assign head      = mem_q[gnt_q][rd_ptr_q[gnt_q]];
  // The first flag travels with each entry but the framer aligns on the packet counter instead
  assign unused_bits = ^{set_data[31:16], head[96]};

  // Clamp the programmed packet length into 1..DEPTH
  always_comb begin
    spp_eff = spp_q;
    if (spp_q == 16'd0)             spp_eff = 16'd1;
    else if (32'(spp_q) > DEPTH)    spp_eff = 16'(DEPTH);
  end

  // Per-channel capture, readiness and pop/seq strobes
  always_comb begin
    for (int c = 0; c < int'(NCHAN); c++) begin
      full[c]    = (occ_q[c] == OW'(DEPTH));
      wr_en[c]   = strobe[c] & run[c] & ~full[c];
      ready[c]   = 32'(occ_q[c]) >= 32'(spp_eff);
      pop_vec[c] = pop & (gnt_q == CW'(c));
      seq_inc[c] = eof_xfer & (gnt_q == CW'(c));
    end
  end

  // Round-robin: lowest ready channel at or after last_granted + 1
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int unsigned i = 1; i <= NCHAN; i++) begin
      if (!grant_vld && ready[rr_idx(last_q, i)]) begin
        grant_vld = 1'b1;
        grant_ch  = rr_idx(last_q, i);
      end
    end
  end

  // Settings registers; a pending clear holds until the framer is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= '0;
      spp_q    <= 16'd16;
      clear_q  <= 1'b0;
    end else begin
      if (do_clear) clear_q <= 1'b0;
      if (set_stb) begin
        if (set_addr == 8'(BASE))     enable_q <= set_data[NCHAN-1:0];
        if (set_addr == 8'(BASE + 1)) spp_q    <= set_data[15:0];
        if (set_addr == 8'(BASE + 2)) clear_q  <= 1'b1;
      end
    end
  end

  // Buffer storage, no reset needed
  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(NCHAN); c++) begin
      if (wr_en[c]) mem_q[c][wr_ptr_q[c]] <= {cnt_q[c] == 16'd0, vita_time, sample[32*c +: 32]};
    end
  end

  // Buffer pointers, occupancy, packet counters, sequence numbers and overrun flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= '0;
      for (int c = 0; c < int'(NCHAN); c++) begin
        occ_q[c]    <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
        seq_q[c]    <= '0;
      end
    end else if (do_clear) begin
      overrun_q <= '0;
      for (int c = 0; c < int'(NCHAN); c++) begin
        occ_q[c]    <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
        seq_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < int'(NCHAN); c++) begin
        occ_q[c] <= occ_q[c] + OW'(wr_en[c]) - OW'(pop_vec[c]);
        if (wr_en[c]) begin
          wr_ptr_q[c] <= wr_ptr_q[c] + AW'(1);
          cnt_q[c]    <= (cnt_q[c] >= spp_eff - 16'd1) ? 16'd0 : cnt_q[c] + 16'd1;
        end
        if (strobe[c] && run[c] && full[c]) overrun_q[c] <= 1'b1;
        if (pop_vec[c]) rd_ptr_q[c] <= rd_ptr_q[c] + AW'(1);
        if (seq_inc[c]) seq_q[c] <= seq_q[c] + 8'd1;
      end
    end
  end

  // Framer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      last_q    <= CW'(NCHAN - 1);
      rem_q     <= '0;
      data_q    <= '0;
      src_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      src_rdy_q <= src_rdy_d;
    end
  end

  // Framer next state: each transfer loads the following word into the output register
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    rem_d     = rem_q;
    data_d    = data_q;
    src_rdy_d = src_rdy_q;
    unique case (state_q)
      StIdle: begin
        if (clear_q) begin
          last_d = CW'(NCHAN - 1);
        end else if (grant_vld) begin
          gnt_d     = grant_ch;
          last_d    = grant_ch;
          rem_d     = spp_eff;
          data_d    = {4'b0001, 8'(grant_ch), seq_q[grant_ch], spp_eff};
          src_rdy_d = 1'b1;
          state_d   = StHdr;
        end
      end
      StHdr: if (xfer) begin
        data_d  = {4'b0000, head[95:64]};
        state_d = StTsh;
      end
      StTsh: if (xfer) begin
        data_d  = {4'b0000, head[63:32]};
        state_d = StTsl;
      end
      StTsl: if (xfer) begin
        data_d  = {2'b00, rem_q == 16'd1, 1'b0, head[31:0]};
        rem_d   = rem_q - 16'd1;
        state_d = StData;
      end
      StData: if (xfer) begin
        if (data_q[33]) begin
          data_d    = '0;
          src_rdy_d = 1'b0;
          state_d   = StIdle;
        end else begin
          data_d = {2'b00, rem_q == 16'd1, 1'b0, head[31:0]};
          rem_d  = rem_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
